// File: rtl/mac_dot_seq.sv
// Sequencer for a BF16 dot product built around an external combinational MAC.
// The block streams operand pairs to the MAC and holds the FP32 running sum in
// an accumulator register. After the last pair it presents the sum on res and
// holds it until the consumer accepts it.
module mac_dot_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic [31:0]      mac_acc,
  input  logic [31:0]      mac_res,
  output logic [31:0]      res,
  output logic             res_valid,
  input  logic             res_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic [31:0]      acc;
  logic [31:0]      acc_nxt;
  logic             beat;

  // A beat is an accepted operand pair; acceptance is possible only in RUN.
  assign beat = in_valid && (state == RUN);

  // Status and MAC hookup are plain decodes of the registers, so they carry no
  // combinational path from inputs except the operand pass-through to the MAC.
  assign busy      = (state != IDLE);
  assign in_ready  = (state == RUN);
  assign res_valid = (state == DONE);
  assign res       = acc;
  assign mac_acc   = acc;
  assign mac_a     = in_a;
  assign mac_b     = in_b;

  // State, remaining-pair count and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= CNT_ZERO;
      acc   <= 32'h0000_0000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
    end
  end

  // Next-state logic: hold everything by default, advance on start, beats and
  // result acceptance. cnt decrements only in RUN where it is at least one.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt = len;
          acc_nxt = 32'h0000_0000;
          if (len != CNT_ZERO) begin
            state_nxt = RUN;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (beat) begin
          acc_nxt = mac_res;
          cnt_nxt = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
          end
        end else begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        // start is ignored here, including on the cycle that returns to IDLE.
        if (res_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = CNT_ZERO;
        acc_nxt   = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Self-checking bench for mac_dot_seq. A behavioural FP MAC (via real arithmetic)
// stands in for the external MAC. A transaction-level model predicts busy,
// in_ready, res_valid and res on every cycle, and literal expectations pin the
// final results of each scenario.
module tb_mac_dot_seq;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      mac_a;
  logic [15:0]      mac_b;
  logic [31:0]      mac_acc;
  logic [31:0]      mac_res;
  logic [31:0]      res;
  logic             res_valid;
  logic             res_ready;

  int tests = 0;
  int fails = 0;
  int ready_cycles = 0;

  mac_dot_seq #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
    .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc), .mac_res(mac_res),
    .res(res), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // FP32 bit pattern to real (normals and zero).
  function automatic real f32_to_real(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'd0) begin
      d = {f[31], 63'd0};
    end else begin
      e = {3'b000, f[30:23]} + 11'd896;
      d = {f[31], e, f[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  // Real to FP32 bit pattern (truncating; all bench values are exact).
  function automatic logic [31:0] real_to_f32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (r == 0.0) begin
      return {d[63], 31'd0};
    end
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_mac(input logic [15:0] a, input logic [15:0] b,
                                          input logic [31:0] acc);
    real ra, rb, rc;
    ra = f32_to_real({a, 16'h0000});
    rb = f32_to_real({b, 16'h0000});
    rc = f32_to_real(acc);
    return real_to_f32(ra * rb + rc);
  endfunction

  // External MAC stand-in.
  assign mac_res = fp_mac(mac_a, mac_b, mac_acc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase of the job, pairs still owed, running sum.
  typedef enum int {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t     m_ph;
  int          m_left;
  logic [31:0] m_sum;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph   <= M_IDLE;
      m_left <= 0;
      m_sum  <= 32'h0;
    end else begin
      if (m_ph == M_IDLE && start) begin
        m_sum  <= 32'h0;
        m_left <= int'(len);
        m_ph   <= (len == 8'd0) ? M_DONE : M_RUN;
      end else if (m_ph == M_RUN && in_valid) begin
        m_sum  <= fp_mac(in_a, in_b, m_sum);
        m_left <= m_left - 1;
        if (m_left == 1) m_ph <= M_DONE;
      end else if (m_ph == M_DONE && res_ready) begin
        m_ph <= M_IDLE;
      end
    end
  end

  // Per-cycle compare of all status outputs against the model.
  always begin
    @(posedge clk);
    #2;
    if (!rst) begin
      chk("busy", {31'd0, busy}, {31'd0, m_ph != M_IDLE});
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ph == M_RUN});
      chk("res_valid", {31'd0, res_valid}, {31'd0, m_ph == M_DONE});
      chk("res", res, m_sum);
      if (in_ready) ready_cycles++;
    end
  end

  task automatic do_start(input logic [LEN_W-1:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive pairs from the current negedge until n beats are accepted; in_valid
  // follows vpat (bit i for cycle i, repeating every plen cycles). Ends on the
  // negedge after the final beat.
  task automatic feed(input logic [15:0] a, input logic [15:0] b, input int n,
                      input logic [15:0] vpat, input int plen);
    int got = 0;
    int idx = 0;
    while (got < n && idx < 2000) begin
      in_a     = a;
      in_b     = b;
      in_valid = vpat[idx % plen];
      if (in_valid && in_ready) got++;
      idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("feed_beats", got, n);
  endtask

  // Expect the result right now (one cycle after the last beat), then accept.
  task automatic take_result(input string name, input logic [31:0] exp);
    chk({name, "_valid"}, {31'd0, res_valid}, 32'd1);
    chk(name, res, exp);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_a = 16'h0; in_b = 16'h0;
    in_valid = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res", res, 32'h0);
    rst = 1'b0;

    // len=3 of 1.0*2.0 -> 6.0
    do_start(8'd3);
    feed(16'h3F80, 16'h4000, 3, 16'hFFFF, 1);
    take_result("sum6", 32'h40C0_0000);

    // len=0 -> DONE next cycle with zero result
    do_start(8'd0);
    chk("len0_in_ready", {31'd0, in_ready}, 32'd0);
    take_result("len0", 32'h0000_0000);

    // len=4 with bubbles 1,0,0,1,1,0,1 -> 4.0
    do_start(8'd4);
    feed(16'h3F80, 16'h3F80, 4, 16'b0000_0000_0101_1001, 7);
    take_result("bubbles", 32'h4080_0000);

    // Backpressure: result held for 5 cycles, starts ignored meanwhile
    do_start(8'd2);
    feed(16'h4000, 16'h3F80, 2, 16'hFFFF, 1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_res", res, 32'h4080_0000);
      start = 1'b1;
      len   = 8'd7;
      @(negedge clk);
    end
    chk("hold_still_done", {31'd0, res_valid}, 32'd1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    chk("release_idle", {31'd0, busy}, 32'd0);

    // Reset after 2 of 5 beats, then a fresh len=1 run accepted immediately
    do_start(8'd5);
    feed(16'h3F80, 16'h3F80, 2, 16'hFFFF, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_res_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_res", res, 32'h0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    len   = 8'd1;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_start", {31'd0, busy}, 32'd1);
    feed(16'h4000, 16'h4000, 1, 16'hFFFF, 1);
    take_result("post_rst", 32'h4080_0000);

    // Maximum length, back-to-back
    ready_cycles = 0;
    do_start(8'd255);
    feed(16'h3F80, 16'h3F80, 255, 16'hFFFF, 1);
    chk("max_ready_cycles", ready_cycles, 32'd255);
    take_result("max_len", 32'h437F_0000);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
